al_apb_regbank_responder: RTL

- APB completer (slave end) that answers transfers from the APB requester side of the block's testbench interfaces.
- Implements a small register bank with programmable wait states, error responses and a completed-transfer counter.
- Sits behind the APB interface slave modport in the DCD testbench. It serves as the register target for bring-up of the APB VIP and for register-path checks.

---
 rtl/al_apb_regbank_responder_if.sv | 24 ++
 rtl/al_apb_regbank_responder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/al_apb_regbank_responder_if.sv
// APB bus bundle between the testbench requester and the register-bank completer.
// The requester drives the master modport; the responder consumes the slave modport.
interface al_apb_regbank_responder_if #(
  parameter int ADDR = 20
);
  logic [ADDR-1:0] addr;
  logic            sel;
  logic            enable;
  logic            write;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;
  logic            slverr;

  modport master (
    output addr, sel, enable, write, wdata,
    input  rdata, ready, slverr
  );

  modport slave (
    input  addr, sel, enable, write, wdata,
    output rdata, ready, slverr
  );
endinterface

// File: rtl/al_apb_regbank_responder.sv
// APB completer with an ID register, a completed-transfer counter and RW registers.
// Define AL_APB_RESP_RAND_WAIT_EN for LFSR-driven wait states in 0..WAIT_CYCLES.
module al_apb_regbank_responder #(
  parameter int          ADDR        = 20,
  parameter int          NUM_REGS    = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA1B0_0001
) (
  input logic                        clk,
  input logic                        rstn,
  al_apb_regbank_responder_if.slave  apb
);

  localparam int IDX_W  = ADDR - 2;
  localparam int RIDX_W = $clog2(NUM_REGS);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state, state_nx;
  logic [1:0]        cap_lo;
  logic              cap_write;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        cnt;
  logic [3:0]        cnt_load;
  logic [31:0]       xfer_cnt;
  logic [31:0]       regs [NUM_REGS];
  logic              setup;
  logic              err;
  logic [RIDX_W-1:0] ridx;
  logic [31:0]       rd_val;

  assign setup = (state == IDLE) && apb.sel && !apb.enable;
  assign ridx  = idx[RIDX_W-1:0];

  // Errors are judged on the request captured in SETUP, never on live bus values.
  assign err = (cap_lo != 2'b00)
            || (32'(idx) >= 32'(NUM_REGS))
            || (cap_write && (32'(idx) < 32'd2));

  assign apb.ready  = (state == ACCESS) && apb.sel && apb.enable && (cnt == 4'd0);
  assign apb.slverr = apb.ready && err;
  assign apb.rdata  = (apb.ready && !cap_write && !err) ? rd_val : '0;

`ifdef AL_APB_RESP_RAND_WAIT_EN
  logic [7:0] lfsr;
  logic [4:0] lfsr_mod;

  // Five-bit modulo keeps WAIT_CYCLES=15 (divisor 16) well defined.
  assign lfsr_mod = {1'b0, lfsr[3:0]} % 5'(WAIT_CYCLES + 1);
  assign cnt_load = lfsr_mod[3:0];

  // x^8+x^6+x^5+x^4+1; the pre-advance value sizes the transfer being set up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= 8'hA5;
    end else if (setup) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  assign cnt_load = 4'(WAIT_CYCLES);
`endif

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    rd_val = regs[ridx];
    if (32'(idx) == 32'd0) begin
      rd_val = ID_VALUE;
    end else if (32'(idx) == 32'd1) begin
      rd_val = xfer_cnt;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (setup) state_nx = ACCESS;
      ACCESS:  if (!apb.sel || apb.ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cap_lo    <= '0;
      cap_write <= 1'b0;
      idx       <= '0;
      cnt       <= '0;
      xfer_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (setup) begin
        cap_lo    <= apb.addr[1:0];
        cap_write <= apb.write;
        idx       <= apb.addr[ADDR-1:2];
        cnt       <= cnt_load;
      end else if ((state == ACCESS) && apb.sel && apb.enable && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // Error transfers still complete, so they are counted as well.
      if (apb.ready) begin
        xfer_cnt <= xfer_cnt + 32'd1;
      end
    end
  end

  // NOTE: the register array is reset on purpose: a reset mid-transfer must clear every RW register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (apb.ready && cap_write && !err) begin
      regs[ridx] <= apb.wdata;
    end
  end

endmodule
